// File: rtl/ccff_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
package ccff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Counter width able to hold the value n itself.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream from the JTAG/SPI front end into the loader.
interface ccff_chain_loader_if #(
   parameter int unsigned WORD_W = 32
);
   logic [WORD_W-1:0] cfg_word;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_word, output cfg_valid, input  cfg_ready);
   modport slave  (input  cfg_word, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// Parallel-load word register with a bit index walking MSB to LSB.
module ccff_word_serializer #(
   parameter int unsigned WORD_W = 32
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              load,
   input  logic              advance,
   input  logic [WORD_W-1:0] word,
   output logic              next_bit_c,
   output logic              last_c
);
   localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   logic [WORD_W-1:0] sreg;
   logic [IDX_W-1:0]  bit_idx;

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         sreg    <= '0;
         bit_idx <= '0;
      end else if (load) begin
         sreg    <= word;
         bit_idx <= IDX_W'(WORD_W - 1);
      end else if (advance) begin
         bit_idx <= bit_idx - IDX_W'(1);
      end
   end

   // Bit that will sit on the chain input in the cycle after this one.
   always_comb begin
      next_bit_c = 1'b0;
      if (load) next_bit_c = word[WORD_W-1];
      else      next_bit_c = sreg[bit_idx - IDX_W'(1)];
   end

   assign last_c = (bit_idx == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Shifts a word-streamed bitstream into the tile config chain, with optional tail verify.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter  int unsigned WORD_W    = 32,
   parameter  int unsigned CHAIN_LEN = 1024,
   localparam int unsigned CNT_W     = cnt_width(CHAIN_LEN)
) (
   input  logic                prog_clk,
   input  logic                pReset,
   input  logic                start,
   input  logic                verify,
   ccff_chain_loader_if.slave  cfg,
   output logic                ccff_head,
   output logic                ccff_shift_en,
   input  logic                ccff_tail,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [CNT_W-1:0]    bit_cnt,
   output logic [CNT_W-1:0]    mismatch_cnt
);
   state_t           state, state_n;
   logic             verify_q, verify_n;
   logic [CNT_W-1:0] bit_cnt_n, mismatch_n;
   logic             err_n, ready_n, shift_en_n, head_n, busy_n, done_n;
   logic             load, advance, next_bit_c, last_c, mismatch_c;

   ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
      .prog_clk   (prog_clk),
      .pReset     (pReset),
      .load       (load),
      .advance    (advance),
      .word       (cfg.cfg_word),
      .next_bit_c (next_bit_c),
      .last_c     (last_c)
   );

   // Tail and head are compared in the same shift cycle.
   assign mismatch_c = verify_q && (ccff_head != ccff_tail);

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state         <= ST_IDLE;
         verify_q      <= 1'b0;
         bit_cnt       <= '0;
         mismatch_cnt  <= '0;
         err           <= 1'b0;
         cfg.cfg_ready <= 1'b0;
         ccff_shift_en <= 1'b0;
         ccff_head     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_n;
         verify_q      <= verify_n;
         bit_cnt       <= bit_cnt_n;
         mismatch_cnt  <= mismatch_n;
         err           <= err_n;
         cfg.cfg_ready <= ready_n;
         ccff_shift_en <= shift_en_n;
         ccff_head     <= head_n;
         busy          <= busy_n;
         done          <= done_n;
      end
   end

   always_comb begin
      state_n    = state;
      verify_n   = verify_q;
      bit_cnt_n  = bit_cnt;
      mismatch_n = mismatch_cnt;
      err_n      = err;
      load       = 1'b0;
      advance    = 1'b0;

      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               bit_cnt_n  = '0;
               mismatch_n = '0;
               err_n      = 1'b0;
               verify_n   = verify;
               state_n    = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (cfg.cfg_valid && cfg.cfg_ready) begin
               load    = 1'b1;
               state_n = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            advance   = 1'b1;
            bit_cnt_n = bit_cnt + CNT_W'(1);
            if (mismatch_c) mismatch_n = mismatch_cnt + CNT_W'(1);
            // Chain full: leftover bits of the current word are dropped.
            if (bit_cnt_n == CNT_W'(CHAIN_LEN)) begin
               state_n = ST_DONE;
               err_n   = verify_q && (mismatch_n != '0);
            end else if (last_c) begin
               state_n = ST_FETCH;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      ready_n    = (state_n == ST_FETCH);
      shift_en_n = (state_n == ST_SHIFT);
      head_n     = shift_en_n ? next_bit_c : 1'b0;
      busy_n     = (state_n == ST_FETCH) || (state_n == ST_SHIFT);
      done_n     = (state_n == ST_DONE);
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: table of load/verify passes against a 10-bit chain model.
module tb_ccff_chain_loader;
   localparam int unsigned WORD_W    = 4;
   localparam int unsigned CHAIN_LEN = 10;
   localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);

   logic             prog_clk = 1'b0;
   logic             pReset, start, verify, ccff_tail;
   logic             ccff_head, ccff_shift_en, busy, done, err;
   logic [CNT_W-1:0] bit_cnt, mismatch_cnt;
   logic [CHAIN_LEN-1:0] chain = '0;

   int checks = 0;
   int errors = 0;

   ccff_chain_loader_if #(.WORD_W(WORD_W)) cfg_if ();

   ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
      .prog_clk      (prog_clk),
      .pReset        (pReset),
      .start         (start),
      .verify        (verify),
      .cfg           (cfg_if.slave),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .bit_cnt       (bit_cnt),
      .mismatch_cnt  (mismatch_cnt)
   );

   always #5 prog_clk = ~prog_clk;

   // Behavioural tile chain: head enters bit 0, tail is the oldest bit.
   always_ff @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   assign ccff_tail = chain[CHAIN_LEN-1];

   typedef struct {
      string           name;
      logic            vfy;
      logic [2:0][3:0] words;      // words[0] is sent first
      int              stall;      // FETCH cycles with cfg_valid low
      logic            mid_start;  // pulse start during SHIFT
      logic [9:0]      exp_head;   // bit 9 is the first shifted
      int              exp_mm;
      logic            exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " cfg_ready"}, int'(cfg_if.cfg_ready), 0);
      chk({tag, " head"}, int'(ccff_head), 0);
      chk({tag, " shift_en"}, int'(ccff_shift_en), 0);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " done"}, int'(done), 0);
      chk({tag, " err"}, int'(err), 0);
      chk({tag, " bit_cnt"}, int'(bit_cnt), 0);
      chk({tag, " mismatch_cnt"}, int'(mismatch_cnt), 0);
   endtask

   task automatic run_pass(input int r);
      vec_t v;
      logic [9:0] seq;
      int nsh, widx, nfetch, stall_left, cyc;
      logic prev_se, saw_done, stall_shift;
      v = vecs[r];
      seq = '0; nsh = 0; widx = 0; nfetch = 0; stall_left = v.stall;
      prev_se = 1'b0; saw_done = 1'b0; stall_shift = 1'b0;

      start = 1'b1; verify = v.vfy; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_word = 4'hF;
      tick();
      start = 1'b0; verify = 1'b0;
      chk({v.name, " fetch ready"}, int'(cfg_if.cfg_ready), 1);
      chk({v.name, " fetch busy"}, int'(busy), 1);
      chk({v.name, " cleared"}, int'({done, err, bit_cnt, mismatch_cnt}), 0);

      for (cyc = 0; cyc < 200; cyc++) begin
         if (done) begin
            saw_done = 1'b1;
            break;
         end
         if (ccff_shift_en) begin
            if (nsh < 10) seq[9-nsh] = ccff_head;
            nsh++;
         end
         if (cfg_if.cfg_ready) nfetch++;
         if (cfg_if.cfg_ready && stall_left > 0) begin
            cfg_if.cfg_valid = 1'b0;
            stall_left--;
            if (ccff_shift_en) stall_shift = 1'b1;
         end else begin
            cfg_if.cfg_valid = 1'b1;
         end
         cfg_if.cfg_word = (widx < 3) ? v.words[widx] : 4'hF;
         if (cfg_if.cfg_valid && cfg_if.cfg_ready) widx++;
         if (v.mid_start && ccff_shift_en && nsh == 3) begin
            start = 1'b1; verify = 1'b1;
         end else begin
            start = 1'b0; verify = 1'b0;
         end
         prev_se = ccff_shift_en;
         tick();
      end
      start = 1'b0; verify = 1'b0;

      chk({v.name, " done seen"}, int'(saw_done), 1);
      chk({v.name, " head seq"}, int'(seq), int'(v.exp_head));
      chk({v.name, " shift cycles"}, nsh, 10);
      chk({v.name, " words taken"}, widx, 3);
      chk({v.name, " fetch cycles"}, nfetch, 3 + v.stall);
      chk({v.name, " stall shift_en"}, int'(stall_shift), 0);
      chk({v.name, " done after last shift"}, int'(prev_se), 1);
      chk({v.name, " shift_en in done"}, int'(ccff_shift_en), 0);
      chk({v.name, " busy in done"}, int'(busy), 0);
      chk({v.name, " ready in done"}, int'(cfg_if.cfg_ready), 0);
      chk({v.name, " bit_cnt"}, int'(bit_cnt), 10);
      chk({v.name, " mismatch_cnt"}, int'(mismatch_cnt), v.exp_mm);
      chk({v.name, " err"}, int'(err), int'(v.exp_err));
      tick();
      chk({v.name, " done holds"}, int'(done), 1);
   endtask

   task automatic mid_reset();
      int nsh;
      logic hit;
      nsh = 0; hit = 1'b0;
      start = 1'b1; verify = 1'b0; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_word = 4'hA;
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (ccff_shift_en) nsh++;
         cfg_if.cfg_word = 4'h5;
         if (nsh == 5) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      chk("reset reached shift 5", int'(hit), 1);
      pReset = 1'b1;
      tick();
      pReset = 1'b0;
      chk_idle("mid reset");
      tick();
      chk("mid reset stays idle", int'(busy), 0);
   endtask

   initial begin
      vecs[0] = '{"load",        1'b0, {4'hC, 4'h5, 4'hA}, 0, 1'b0, 10'b1010_0101_11, 0, 1'b0};
      vecs[1] = '{"load stall",  1'b0, {4'hC, 4'h5, 4'hA}, 3, 1'b0, 10'b1010_0101_11, 0, 1'b0};
      vecs[2] = '{"verify same", 1'b1, {4'hC, 4'h5, 4'hA}, 0, 1'b0, 10'b1010_0101_11, 0, 1'b0};
      vecs[3] = '{"verify flip", 1'b1, {4'hC, 4'h5, 4'h2}, 0, 1'b0, 10'b0010_0101_11, 1, 1'b1};
      vecs[4] = '{"reload mid start", 1'b0, {4'hC, 4'h5, 4'hA}, 0, 1'b1, 10'b1010_0101_11, 0, 1'b0};
      vecs[5] = '{"verify again", 1'b1, {4'hC, 4'h5, 4'hA}, 2, 1'b0, 10'b1010_0101_11, 0, 1'b0};

      pReset = 1'b1; start = 1'b0; verify = 1'b0;
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_word = '0;
      tick();
      tick();
      chk_idle("reset");
      pReset = 1'b0;
      cfg_if.cfg_valid = 1'b1;
      tick();
      chk("idle ignores valid", int'(cfg_if.cfg_ready), 0);

      for (int r = 0; r < 4; r++) run_pass(r);
      mid_reset();
      for (int r = 4; r < 6; r++) run_pass(r);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
